// File: rtl/ref_clk_monitor.sv
// Gate-window frequency monitor for CH_COUNT divided reference toggles with priority source selection.
// Optional upgrade hold-off after each switch is enabled by defining REF_CLK_MONITOR_HOLDOFF_EN.
`timescale 1ns/1ps
module ref_clk_monitor #(
  parameter int CH_COUNT      = 2,
  parameter int GATE_WIDTH    = 8,
  parameter int COUNT_WIDTH   = 8,
  parameter int WIN1_MIN      = 10,
  parameter int WIN1_MAX      = 11,
  parameter int WIN2_MIN      = 9,
  parameter int WIN2_MAX      = 12,
  parameter int VALID_WIDTH   = 7,
  parameter int HOLDOFF_GATES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CH_COUNT-1:0]         ref_toggle,
  input  logic [CH_COUNT-1:0]         ch_enable,
  output logic [CH_COUNT-1:0]         ref_valid,
  output logic [$clog2(CH_COUNT)-1:0] sel,
  output logic                        switch_pulse,
  output logic                        gate
);

  localparam int SEL_W = $clog2(CH_COUNT);
  localparam logic [COUNT_WIDTH-1:0] W1_LO = COUNT_WIDTH'(WIN1_MIN);
  localparam logic [COUNT_WIDTH-1:0] W1_HI = COUNT_WIDTH'(WIN1_MAX);
  localparam logic [COUNT_WIDTH-1:0] W2_LO = COUNT_WIDTH'(WIN2_MIN);
  localparam logic [COUNT_WIDTH-1:0] W2_HI = COUNT_WIDTH'(WIN2_MAX);

  logic [GATE_WIDTH-1:0] gate_cnt_reg;
  logic                  gate_reg;
  logic                  gate_hit;
  logic [CH_COUNT-1:0]   valid_vec;
  logic [SEL_W-1:0]      cand;
  logic [SEL_W-1:0]      sel_reg;
  logic                  switch_reg;

  assign gate_hit = (gate_cnt_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt_reg <= '0;
      gate_reg     <= 1'b0;
    end else begin
      gate_cnt_reg <= gate_cnt_reg + GATE_WIDTH'(1);
      gate_reg     <= gate_hit;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH_COUNT; gi++) begin : g_ch
      logic [2:0]             sync_reg;
      logic                   hist_reg;
      logic                   edge_det;
      logic [COUNT_WIDTH-1:0] edge_cnt_reg;
      logic [VALID_WIDTH-1:0] vld_cnt_reg;
      logic                   valid_reg;
      logic                   in_w1;
      logic                   out_w2;

      assign edge_det = sync_reg[2] ^ hist_reg;
      assign in_w1    = (edge_cnt_reg >= W1_LO) && (edge_cnt_reg <= W1_HI);
      assign out_w2   = (edge_cnt_reg < W2_LO) || (edge_cnt_reg > W2_HI);
      assign valid_vec[gi] = valid_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_reg     <= '0;
          hist_reg     <= 1'b0;
          edge_cnt_reg <= '0;
          vld_cnt_reg  <= '0;
          valid_reg    <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[1:0], ref_toggle[gi]};
          hist_reg <= sync_reg[2];

          // The edge seen in the gate cycle itself belongs to the next window.
          if (gate_hit)
            edge_cnt_reg <= {{(COUNT_WIDTH-1){1'b0}}, edge_det};
          else if (edge_det && (edge_cnt_reg != '1))
            edge_cnt_reg <= edge_cnt_reg + COUNT_WIDTH'(1);

          if (!ch_enable[gi]) begin
            vld_cnt_reg <= '0;
            valid_reg   <= 1'b0;
          end else if (gate_hit) begin
            if (in_w1) begin
              if (vld_cnt_reg == '1)
                valid_reg <= 1'b1;
              else
                vld_cnt_reg <= vld_cnt_reg + VALID_WIDTH'(1);
            end else if (out_w2) begin
              if (vld_cnt_reg != '0)
                vld_cnt_reg <= vld_cnt_reg - VALID_WIDTH'(1);
              else
                valid_reg <= 1'b0;
            end
          end
        end
      end
    end
  endgenerate

  // Highest valid channel above 0 wins; channel 0 is the failsafe fallback.
  always_comb begin
    cand = '0;
    for (int i = 1; i < CH_COUNT; i++) begin
      if (valid_vec[i])
        cand = SEL_W'(i);
    end
  end

`ifdef REF_CLK_MONITOR_HOLDOFF_EN
  localparam int HO_W = $clog2(HOLDOFF_GATES + 2);
  logic [HO_W-1:0] holdoff_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg     <= '0;
      switch_reg  <= 1'b0;
      holdoff_reg <= '0;
    end else begin
      switch_reg <= 1'b0;
      if (gate_hit && (holdoff_reg != '0))
        holdoff_reg <= holdoff_reg - HO_W'(1);
      // Downgrades are never delayed; upgrades wait for the hold-off to expire.
      if ((cand < sel_reg) || ((cand > sel_reg) && (holdoff_reg == '0))) begin
        sel_reg     <= cand;
        switch_reg  <= 1'b1;
        holdoff_reg <= HO_W'(HOLDOFF_GATES);
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg    <= '0;
      switch_reg <= 1'b0;
    end else begin
      switch_reg <= 1'b0;
      if (cand != sel_reg) begin
        sel_reg    <= cand;
        switch_reg <= 1'b1;
      end
    end
  end
`endif

  assign ref_valid    = valid_vec;
  assign sel          = sel_reg;
  assign switch_pulse = switch_reg;
  assign gate         = gate_reg;

endmodule
